calc_btn_cond: RTL
==================

// Module: calc_btn_cond
// PURPOSE
//  Conditions the raw Basys3 push-buttons before they reach the calculator encoder and accumulator.
//  Each button passes through a 2-FF synchroniser, then a per-button debounce FSM.
//  The debounced btnc/btnl/btnr levels drive calc_enc directly to select alu_op.
//  The debounced btnd produces a single-cycle exec_pulse that tells the accumulator to apply alu_op.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000  consecutive stable synced cycles required to accept a new level (10 ms @100 MHz); legal >= 2
//  CNT_W            20         debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst         in   1  synchronous, active-high reset
//  btnc_raw    in   1  raw centre button (asynchronous, bouncy)
//  btnl_raw    in   1  raw left button
//  btnr_raw    in   1  raw right button
//  btnd_raw    in   1  raw down button (execute)
//  btnc        out  1  debounced level of centre button, to calc_enc
//  btnl        out  1  debounced level of left button, to calc_enc
//  btnr        out  1  debounced level of right button, to calc_enc
//  btnd_db     out  1  debounced level of down button
//  exec_pulse  out  1  one-cycle pulse on each debounced 0->1 of btnd
// BEHAVIOUR
//  Reset
//   - rst sampled high: all sync FFs, counters and FSMs clear; every output = 0 on the next edge.
//   - rst dominates every other event, including reset asserted mid-debounce or mid-pulse.
//  Synchroniser
//   - raw -> s1 -> s2, two flops; s2 is the only signal the FSM sees.
//  Debounce FSM (identical instance per button, 4 states)
//   - LOW:     out=0; s2=1 -> RISE, cnt=1.
//   - RISE:    out=0; s2=0 -> LOW, cnt=0 (bounce rejected).
//              s2=1 and cnt==DEBOUNCE_CYCLES-1 -> HIGH, cnt=0; otherwise cnt++.
//   - HIGH:    out=1; s2=0 -> FALL, cnt=1.
//   - FALL:    out=1; s2=1 -> HIGH, cnt=0.
//              s2=0 and cnt==DEBOUNCE_CYCLES-1 -> LOW, cnt=0; otherwise cnt++.
//   - out is registered, equal to 1 exactly in HIGH and FALL.
//  Latency
//   - Raw level held steady: out changes on the (2+DEBOUNCE_CYCLES)th rising edge after the first edge that samples the new raw level.
//   - Any opposite s2 sample before that restarts qualification from zero; no partial credit.
//  exec_pulse
//   - Registered; high for exactly the one cycle in which btnd_db first reads 1 after reading 0.
//   - Holding btnd never re-fires; the next pulse requires a debounced release then a new press.
//   - Release never pulses.
//  Independence
//   - Buttons are fully independent; simultaneous presses qualify in parallel with no interaction.
//   - A btnd press while btnc/btnl/btnr are still qualifying still pulses; the consumer sees whatever calc_enc outputs that cycle.
//  Counter
//   - Saturation is impossible because the FSM leaves RISE/FALL at DEBOUNCE_CYCLES-1.
//   - The counter is don't-care (held 0) in LOW/HIGH.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1 rst=1 for 3 cycles with all raw=1 -> all outputs 0 throughout; release rst, raw held 1 -> btnc/btnl/btnr/btnd_db = 1 exactly 6 edges later, exec_pulse=1 for 1 cycle.
//  2 btnc_raw 0->1 held -> btnc rises on edge 6; btnl/btnr stay 0; calc_enc alu_op follows.
//  3 btnl_raw toggles 1,0,1,0 each cycle then holds 1 -> no btnl change during bounce; rises 6 edges after the final 0->1.
//  4 btnd_raw held 1 for 50 cycles, then 0 for 10, then 1 -> exactly two exec_pulses, each 1 cycle wide, each aligned with btnd_db 0->1.
//  5 btnr_raw high 3 cycles (one short of qualifying) then 0 -> btnr never asserts.
//  6 btnd in FALL (btnd_db=1, 2 cycles into release) then rst=1 -> btnd_db=0 next edge, no exec_pulse after rst drops while raw stays 0.

Source files
------------

// File: rtl/calc_btn_cond.sv
`default_nettype none
// ============================================================================
// Module   : calc_btn_cond
// Brief    : Basys3 push-button conditioner: 2-FF sync + debounce FSM per
//            button, plus a one-cycle execute pulse on each debounced btnd press.
// Revision : 1.0 - initial release
// ============================================================================
module calc_btn_cond #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btnc_raw,
  input  logic btnl_raw,
  input  logic btnr_raw,
  input  logic btnd_raw,
  output logic btnc,
  output logic btnl,
  output logic btnr,
  output logic btnd_db,
  output logic exec_pulse
);

  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_RISE = 2'd1,
    ST_HIGH = 2'd2,
    ST_FALL = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Bit order shared by all vectors: [3]=c, [2]=l, [1]=r, [0]=d.
  logic [3:0] raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] db;
  logic [3:0] db_nx;
  logic       exec_q;

  assign raw = {btnc_raw, btnl_raw, btnr_raw, btnd_raw};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_btn
    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             out_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        state <= ST_LOW;
        cnt   <= '0;
        out_q <= 1'b0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
        out_q <= db_nx[i];
      end
    end

    always_comb begin
      state_nx = state;
      cnt_nx   = '0;
      case (state)
        ST_LOW: begin
          if (sync2[i]) begin
            state_nx = ST_RISE;
            cnt_nx   = CNT_ONE;
          end
        end
        ST_RISE: begin
          if (!sync2[i]) begin
            state_nx = ST_LOW;
          end else if (cnt == CNT_LAST) begin
            state_nx = ST_HIGH;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!sync2[i]) begin
            state_nx = ST_FALL;
            cnt_nx   = CNT_ONE;
          end
        end
        ST_FALL: begin
          if (sync2[i]) begin
            state_nx = ST_HIGH;
          end else if (cnt == CNT_LAST) begin
            state_nx = ST_LOW;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
        default: state_nx = ST_LOW;
      endcase
    end

    // Output registered from the next state so it moves on the same edge as the FSM.
    assign db_nx[i] = (state_nx == ST_HIGH) || (state_nx == ST_FALL);
    assign db[i]    = out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exec_q <= 1'b0;
    end else begin
      exec_q <= db_nx[0] & ~db[0];
    end
  end

  assign btnc       = db[3];
  assign btnl       = db[2];
  assign btnr       = db[1];
  assign btnd_db    = db[0];
  assign exec_pulse = exec_q;

endmodule
`default_nettype wire
